tt_um_factory_checker: RTL

TT_UM_FACTORY_CHECKER -- requirements
Module: tt_um_factory_checker

---
 rtl/factory_chk_pkg.sv | 21 ++
 rtl/sat_cnt8.sv | 37 +++
 rtl/tt_um_factory_checker.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/factory_chk_pkg.sv
// Shared definitions for the factory pattern checker.
// Holds the FSM state encoding, the uo_out readback select codes and the
// default lock/loss thresholds used by tt_um_factory_checker.
package factory_chk_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSync   = 2'd1,
    StLocked = 2'd2
  } state_e;

  // Readback select codes on ui_in[2:1]
  localparam logic [1:0] SelStatus = 2'd0;
  localparam logic [1:0] SelErrCnt = 2'd1;
  localparam logic [1:0] SelSample = 2'd2;
  localparam logic [1:0] SelExp    = 2'd3;

  localparam int unsigned SyncLenDefault = 4;
  localparam int unsigned LossLimDefault = 4;

endpackage

// File: rtl/sat_cnt8.sv
// 8-bit saturating up-counter with clear priority.
// Ports:
//   clk_i  - clock
//   rst_ni - asynchronous active-low reset, clears the count
//   inc_i  - increment request; ignored once the count is 8'hFF
//   clr_i  - synchronous clear; wins over a same-cycle increment
//   cnt_o  - current count
module sat_cnt8 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       inc_i,
  input  logic       clr_i,
  output logic [7:0] cnt_o
);

  logic [7:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = 8'h00;
    end else if (inc_i && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= 8'h00;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/tt_um_factory_checker.sv
// Checks an 8-bit incrementing count pattern arriving on uio_in.
// The checker syncs onto the stream (SYNC_LEN consecutive +1 samples), then
// free-runs its own expected value and counts mismatches. LOSS_LIM consecutive
// mismatches drop back to SYNC and set a sticky "lost" flag.
// Ports:
//   clk    - clock
//   rst_n  - asynchronous active-low reset (released through one sync flop)
//   ena    - power-good, unused
//   ui_in  - [0] en, [2:1] readback select, [3] clear err_cnt/lost, [7:4] unused
//   uio_in - pattern data from the device under test
//   uo_out - readback: status / err_cnt / sample / expected value
//   uio_out, uio_oe - tied low, all uio pins are inputs
module tt_um_factory_checker
  import factory_chk_pkg::*;
#(
  parameter int unsigned SYNC_LEN = SyncLenDefault,
  parameter int unsigned LOSS_LIM = LossLimDefault
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [3:0] RunLast  = 4'(SYNC_LEN - 1);
  localparam logic [3:0] MissLast = 4'(LOSS_LIM - 1);

  logic       en, clr;
  logic [1:0] sel;

  assign en  = ui_in[0];
  assign sel = ui_in[2:1];
  assign clr = ui_in[3];

  logic unused_inputs;
  assign unused_inputs = ^{ena, ui_in[7:4]};

  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

  // Internal reset: asserts asynchronously, releases one edge after rst_n rises
  logic rst_sync_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= 1'b0;
    end else begin
      rst_sync_q <= 1'b1;
    end
  end

  state_e     state_d, state_q;
  logic [7:0] s_d, s_q;
  logic [7:0] exp_d, exp_q;
  logic [3:0] run_d, run_q;
  logic [3:0] miss_d, miss_q;
  logic       first_d, first_q;  // next SYNC cycle only reseeds exp
  logic       lost_d, lost_q;
  logic       err_inc;
  logic [7:0] err_cnt;

  always_comb begin
    state_d = state_q;
    s_d     = uio_in;
    exp_d   = exp_q;
    run_d   = run_q;
    miss_d  = miss_q;
    first_d = first_q;
    lost_d  = lost_q;
    err_inc = 1'b0;

    if (!en) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          state_d = StSync;
          first_d = 1'b1;
        end
        StSync: begin
          exp_d = s_q + 8'd1;
          if (first_q) begin
            run_d   = 4'd0;
            first_d = 1'b0;
          end else if (s_q == exp_q) begin
            if (run_q == RunLast) begin
              state_d = StLocked;
              run_d   = 4'd0;
              miss_d  = 4'd0;
            end else begin
              run_d = run_q + 4'd1;
            end
          end else begin
            run_d = 4'd0;
          end
        end
        StLocked: begin
          // Expected value free-runs; the stream is never used to resync here
          exp_d = exp_q + 8'd1;
          if (s_q != exp_q) begin
            err_inc = 1'b1;
            if (miss_q == MissLast) begin
              state_d = StSync;
              first_d = 1'b1;
              lost_d  = 1'b1;
              miss_d  = 4'd0;
            end else begin
              miss_d = miss_q + 4'd1;
            end
          end else begin
            miss_d = 4'd0;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    if (clr) begin
      lost_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      state_q <= StIdle;
      s_q     <= 8'h00;
      exp_q   <= 8'h00;
      run_q   <= 4'd0;
      miss_q  <= 4'd0;
      first_q <= 1'b0;
      lost_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      exp_q   <= exp_d;
      run_q   <= run_d;
      miss_q  <= miss_d;
      first_q <= first_d;
      lost_q  <= lost_d;
    end
  end

  sat_cnt8 u_err_cnt (
    .clk_i  (clk),
    .rst_ni (rst_sync_q),
    .inc_i  (err_inc),
    .clr_i  (clr),
    .cnt_o  (err_cnt)
  );

  logic [1:0] state_bits;
  assign state_bits = state_q;

  always_comb begin
    uo_out = 8'h00;
    case (sel)
      SelStatus: uo_out = {(state_q == StLocked), lost_q, (err_cnt != 8'h00), state_bits, 3'b000};
      SelErrCnt: uo_out = err_cnt;
      SelSample: uo_out = s_q;
      SelExp:    uo_out = exp_q;
      default:   uo_out = 8'h00;
    endcase
  end

endmodule
